// File: rtl/tone_sequencer.sv
// Steps through a small note table and drives the tone divider's select and enable.
// Define SEQ_LOOP_EN to let the loop input restart the melody at its end.
module tone_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              inClk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [2:0]        note_sel,
    output logic              note_on,
    output logic              busy,
    output logic [ADDR_W-1:0] step_addr,
    output logic              done
);

    localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, FINISH} state_t;

    state_t            state, stateNext;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        entry;
    logic [BW-1:0]     beatCnt, beatNext;
    logic [GW-1:0]     gapCnt, gapNext;
    logic [2:0]        beatsLeft, leftNext;
    logic              curRest, restNext;
    logic              curLast, lastNext;
    logic [2:0]        selNext;
    logic              onNext, busyNext, doneNext;
    logic [ADDR_W-1:0] stepNext;

`ifndef SEQ_LOOP_EN
    logic unusedLoop;
    assign unusedLoop = loop;
`endif

    // Table is only writable while idle so a running melody never changes under us
    always_ff @(posedge inClk) begin
        if (wr_en && state == IDLE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign entry = mem[step_addr];

    always_comb begin
        stateNext = state;
        stepNext  = step_addr;
        selNext   = note_sel;
        onNext    = 1'b0;
        doneNext  = 1'b0;
        beatNext  = beatCnt;
        gapNext   = gapCnt;
        leftNext  = beatsLeft;
        restNext  = curRest;
        lastNext  = curLast;
        if (stop) begin
            stateNext = IDLE;
            stepNext  = '0;
            beatNext  = '0;
            gapNext   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        stateNext = LOAD;
                        stepNext  = '0;
                    end
                end
                LOAD: begin
                    selNext   = entry[2:0];
                    leftNext  = entry[5:3];
                    restNext  = entry[6];
                    lastNext  = entry[7];
                    beatNext  = '0;
                    onNext    = ~entry[6];
                    stateNext = PLAY;
                end
                PLAY: begin
                    if (!pause) begin
                        onNext = ~curRest;
                        if (beatCnt == BEAT_LAST) begin
                            beatNext = '0;
                            if (beatsLeft == 3'd0) begin
                                onNext    = 1'b0;
                                gapNext   = '0;
                                stateNext = (GAP_CYCLES == 0) ? FINISH : GAP;
                            end else begin
                                leftNext = beatsLeft - 1'b1;
                            end
                        end else begin
                            beatNext = beatCnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (!pause) begin
                        if (gapCnt == GAP_LAST) begin
                            gapNext   = '0;
                            stateNext = FINISH;
                        end else begin
                            gapNext = gapCnt + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    if (curLast || step_addr == ADDR_LAST) begin
                        stepNext = '0;
`ifdef SEQ_LOOP_EN
                        if (loop) begin
                            stateNext = LOAD;
                        end else begin
                            stateNext = IDLE;
                            doneNext  = 1'b1;
                        end
`else
                        stateNext = IDLE;
                        doneNext  = 1'b1;
`endif
                    end else begin
                        stepNext  = step_addr + 1'b1;
                        stateNext = LOAD;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    stepNext  = '0;
                end
            endcase
        end
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge inClk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            note_sel  <= '0;
            note_on   <= 1'b0;
            busy      <= 1'b0;
            step_addr <= '0;
            done      <= 1'b0;
            beatCnt   <= '0;
            gapCnt    <= '0;
            beatsLeft <= '0;
            curRest   <= 1'b0;
            curLast   <= 1'b0;
        end else begin
            state     <= stateNext;
            note_sel  <= selNext;
            note_on   <= onNext;
            busy      <= busyNext;
            step_addr <= stepNext;
            done      <= doneNext;
            beatCnt   <= beatNext;
            gapCnt    <= gapNext;
            beatsLeft <= leftNext;
            curRest   <= restNext;
            curLast   <= lastNext;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: a table-level model predicts one event per
// played entry plus the done pulse; a monitor measures those events on the outputs.
module tb_tone_sequencer;

    localparam int BEAT  = 4;
    localparam int GAPC  = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          inClk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          loop = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [2:0]    note_sel;
    logic          note_on;
    logic          busy;
    logic [AW-1:0] step_addr;
    logic          done;

    tone_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES(GAPC),
        .DEPTH(DEPTH),
        .ADDR_W(AW)
    ) dut (
        .inClk(inClk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .pause(pause),
        .loop(loop),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .note_sel(note_sel),
        .note_on(note_on),
        .busy(busy),
        .step_addr(step_addr),
        .done(done)
    );

    always #5 inClk = ~inClk;

    typedef struct {
        bit isDone;
        int addr;
        int sel;
        int onCnt;
        int firstOn;
        int lastOn;
        int cycles;
    } ev_t;

    ev_t        expQ[$];
    logic [7:0] tbl[DEPTH];
    bit         modelBusy = 1'b0;
    bit         monOn = 1'b1;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entry timeline: one LOAD cycle, (dur+1) beats of PLAY, GAP, one END cycle
    function automatic ev_t mkEntry(input int i, input int extra);
        ev_t e;
        int  play;
        play      = (int'(tbl[i][5:3]) + 1) * BEAT;
        e.isDone  = 1'b0;
        e.addr    = i;
        e.sel     = int'(tbl[i][2:0]);
        e.onCnt   = tbl[i][6] ? 0 : play;
        e.firstOn = 1;
        e.lastOn  = play + extra;
        e.cycles  = 1 + play + extra + GAPC + 1;
        return e;
    endfunction

    task automatic pushDone();
        ev_t e;
        e = '{1'b1, 0, 0, 0, 0, 0, 0};
        expQ.push_back(e);
    endtask

    task automatic expectSeq(input int passes, input int pauseLen);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                expQ.push_back(mkEntry(i, (p == 0 && i == 0) ? pauseLen : 0));
                if (tbl[i][7]) break;
            end
        end
        pushDone();
    endtask

    int  trkAddr, cyc, onCnt, firstOn, lastOn, selSeen;
    bit  trk = 1'b0;
    bit  selBad;

    task automatic closeEntry();
        ev_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: addr %0d, nothing expected", trkAddr);
            return;
        end
        e = expQ.pop_front();
        check("entry_kind", int'(e.isDone), 0);
        check("entry_addr", trkAddr, e.addr);
        check("entry_on_cycles", onCnt, e.onCnt);
        check("entry_cycles", cyc, e.cycles);
        if (e.onCnt > 0) begin
            check("entry_first_on", firstOn, e.firstOn);
            check("entry_last_on", lastOn, e.lastOn);
            check("entry_sel", selSeen, e.sel);
            check("entry_sel_steady", int'(selBad), 0);
        end
    endtask

    task automatic closeDone();
        ev_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, none expected");
            return;
        end
        e = expQ.pop_front();
        check("done_kind", int'(e.isDone), 1);
        check("done_busy", int'(busy), 0);
    endtask

    always @(negedge inClk) begin
        if (!monOn) begin
            trk = 1'b0;
        end else begin
            if (trk && (!busy || int'(step_addr) != trkAddr)) begin
                closeEntry();
                trk = 1'b0;
            end
            if (busy && !trk) begin
                trk     = 1'b1;
                trkAddr = int'(step_addr);
                cyc     = 0;
                onCnt   = 0;
                firstOn = -1;
                lastOn  = -1;
                selSeen = -1;
                selBad  = 1'b0;
            end
            if (trk) begin
                if (note_on) begin
                    if (onCnt == 0) begin
                        firstOn = cyc;
                        selSeen = int'(note_sel);
                    end else if (int'(note_sel) != selSeen) begin
                        selBad = 1'b1;
                    end
                    onCnt++;
                    lastOn = cyc;
                end
                cyc++;
            end
            if (done) closeDone();
        end
    end

    task automatic writeEntry(input int a, input logic [7:0] d);
        wr_addr = AW'(a);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge inClk);
        wr_en = 1'b0;
        if (!modelBusy) tbl[a] = d;
    endtask

    task automatic randTable(input bit allowLast);
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            d[2:0] = 3'($urandom_range(7));
            d[5:3] = 3'($urandom_range(3));
            d[6]   = ($urandom_range(3) == 0);
            d[7]   = allowLast && ($urandom_range(4) == 0);
            writeEntry(i, d);
        end
    endtask

    task automatic demoTable();
        writeEntry(0, 8'h08);
        writeEntry(1, 8'h05);
        writeEntry(2, 8'h97);
    endtask

    task automatic startSeq();
        start = 1'b1;
        @(negedge inClk);
        start     = 1'b0;
        modelBusy = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (n < budget && (expQ.size() != 0 || busy)) begin
            @(negedge inClk);
            n++;
        end
        check("queue_drained", expQ.size(), 0);
        check("idle_after_seq", int'(busy), 0);
        expQ.delete();
        modelBusy = 1'b0;
        @(negedge inClk);
    endtask

    task automatic countOn(input int addr, input int target, input int budget);
        int seen = 0;
        int n = 0;
        while (seen < target && n < budget) begin
            @(negedge inClk);
            n++;
            if (note_on && int'(step_addr) == addr) seen++;
        end
        check("on_cycle_reached", seen, target);
    endtask

    task automatic waitAddr(input int addr, input int budget);
        int n = 0;
        while (int'(step_addr) != addr && n < budget) begin
            @(negedge inClk);
            n++;
        end
        check("step_addr_reached", int'(step_addr), addr);
    endtask

    initial begin
        #2 reset = 1'b0;
        #2;
        check("rst_note_sel", int'(note_sel), 0);
        check("rst_note_on", int'(note_on), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_addr", int'(step_addr), 0);
        check("rst_done", int'(done), 0);
        @(negedge inClk);
        reset = 1'b1;
        @(negedge inClk);

        randTable(1'b0);
        demoTable();
        expectSeq(1, 0);
        startSeq();
        waitIdle(400);

        for (int r = 0; r < 4; r++) begin
            randTable(1'b1);
            expectSeq(1, 0);
            startSeq();
            waitIdle(400);
        end

        randTable(1'b0);
        expectSeq(1, 0);
        startSeq();
        waitIdle(400);

        demoTable();
        expectSeq(1, 5);
        startSeq();
        countOn(0, 2, 20);
        pause = 1'b1;
        repeat (5) @(negedge inClk);
        pause = 1'b0;
        waitIdle(400);

        expQ.push_back(mkEntry(0, 0));
        begin
            ev_t e;
            e = '{1'b0, 1, 5, 3, 1, 3, 4};
            expQ.push_back(e);
        end
        startSeq();
        countOn(1, 3, 60);
        stop = 1'b1;
        @(negedge inClk);
        check("stop_note_on", int'(note_on), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_step_addr", int'(step_addr), 0);
        check("stop_done", int'(done), 0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge inClk);
            check("start_stop_busy", int'(busy), 0);
        end
        start = 1'b0;
        stop  = 1'b0;
        waitIdle(10);

        writeEntry(0, 8'h4B);
        expectSeq(1, 0);
        startSeq();
        repeat (3) @(negedge inClk);
        writeEntry(0, 8'h07);
        waitIdle(400);
        expectSeq(1, 0);
        startSeq();
        waitIdle(400);

`ifdef SEQ_LOOP_EN
        demoTable();
        loop = 1'b1;
        expectSeq(2, 0);
        startSeq();
        waitAddr(2, 100);
        waitAddr(0, 100);
        waitAddr(1, 100);
        loop = 1'b0;
        waitIdle(400);
`else
        demoTable();
        loop = 1'b1;
        expectSeq(1, 0);
        startSeq();
        waitIdle(400);
        loop = 1'b0;
`endif

        startSeq();
        countOn(0, 3, 20);
        monOn = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_note_on", int'(note_on), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_step_addr", int'(step_addr), 0);
        check("arst_note_sel", int'(note_sel), 0);
        check("arst_done", int'(done), 0);
        @(negedge inClk);
        reset = 1'b1;
        expQ.delete();
        modelBusy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge inClk);
            check("post_rst_busy", int'(busy), 0);
        end
        monOn = 1'b1;
        expectSeq(1, 0);
        startSeq();
        waitIdle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
